// File: rtl/hevc_dct_pkg.sv
// rtl/hevc_dct_pkg.sv - shared constants, state enum and DCT32 coefficient lookup
package hevc_dct_pkg;

    localparam int N = 32;

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        EMIT
    } state_t;

    // Magnitude of the HEVC basis value for angle m*pi/64, m = 0..32.
    function automatic logic [7:0] dct32_base(input logic [5:0] m);
        logic [7:0] v;
        case (m)
            6'd0:  v = 8'd64;  6'd1:  v = 8'd90;  6'd2:  v = 8'd90;  6'd3:  v = 8'd90;
            6'd4:  v = 8'd89;  6'd5:  v = 8'd88;  6'd6:  v = 8'd87;  6'd7:  v = 8'd85;
            6'd8:  v = 8'd83;  6'd9:  v = 8'd82;  6'd10: v = 8'd80;  6'd11: v = 8'd78;
            6'd12: v = 8'd75;  6'd13: v = 8'd73;  6'd14: v = 8'd70;  6'd15: v = 8'd67;
            6'd16: v = 8'd64;  6'd17: v = 8'd61;  6'd18: v = 8'd57;  6'd19: v = 8'd54;
            6'd20: v = 8'd50;  6'd21: v = 8'd46;  6'd22: v = 8'd43;  6'd23: v = 8'd38;
            6'd24: v = 8'd36;  6'd25: v = 8'd31;  6'd26: v = 8'd25;  6'd27: v = 8'd22;
            6'd28: v = 8'd18;  6'd29: v = 8'd13;  6'd30: v = 8'd9;   6'd31: v = 8'd4;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // The 32x32 DCT matrix: C[k][n] follows cos((2n+1)k*pi/64), folded into the first quadrant.
    function automatic logic signed [7:0] dct32_coef(input logic [4:0] k, input logic [4:0] n);
        logic [6:0] m;
        logic       neg;
        logic [7:0] mag;
        m = 7'({1'b0, n, 1'b1}) * 7'({2'b00, k});
        if (m > 7'd64) m = 7'd0 - m;
        neg = (m > 7'd32);
        if (neg) m = 7'd64 - m;
        mag = dct32_base(m[5:0]);
        return neg ? $signed(8'd0 - mag) : $signed(mag);
    endfunction

endpackage

// File: rtl/hevc_fdct32_mac.sv
// rtl/hevc_fdct32_mac.sv - accumulate one DCT row, round and saturate the result
module hevc_fdct32_mac #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    acc_en,
    input  logic signed [7:0]       coef,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [OUT_W-1:0] result
);

    localparam int     ACC_W = IN_W + 13;
    localparam int     RND   = 1 << (SHIFT - 1);
    localparam longint MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MIN_L = -(longint'(1) << (OUT_W - 1));

    logic signed [IN_W+7:0]  prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;

    assign prod = sample * coef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    // One guard bit keeps the rounding add from wrapping near full scale.
    assign rounded = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(RND);
    assign shifted = rounded >>> SHIFT;

    always_comb begin
        result = shifted[OUT_W-1:0];
        if (shifted > (ACC_W+1)'(MAX_L)) begin
            result = OUT_W'(MAX_L);
        end else if (shifted < (ACC_W+1)'(MIN_L)) begin
            result = OUT_W'(MIN_L);
        end
    end

endmodule

// File: rtl/hevc_fdct32_1d.sv
// rtl/hevc_fdct32_1d.sv - serial 32-point HEVC forward DCT, one coefficient per 33 cycles
module hevc_fdct32_1d
    import hevc_dct_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    state_t state, state_nxt;
    logic [4:0] cnt;
    logic [4:0] k;
    logic [4:0] mac_n;
    logic       ready_en;
    logic       accept;
    logic       out_hs;
    logic       mac_clear;
    logic signed [7:0]       coef;
    logic signed [OUT_W-1:0] mac_result;
    logic signed [IN_W-1:0]  samples [N];

    assign accept    = in_valid && in_ready;
    assign out_hs    = (state == EMIT) && out_valid && out_ready;
    assign in_ready  = ready_en && (state == LOAD);
    assign busy      = (state != LOAD);
    assign mac_clear = (accept && cnt == 5'd31) || (out_hs && k != 5'd31);
    assign coef      = dct32_coef(k, mac_n);

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (accept && cnt == 5'd31) state_nxt = MAC;
            MAC:  if (mac_n == 5'd31) state_nxt = EMIT;
            EMIT: if (out_hs) state_nxt = (k == 5'd31) ? LOAD : MAC;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            k         <= '0;
            mac_n     <= '0;
            ready_en  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (accept) cnt <= cnt + 5'd1;
            if (state == MAC) mac_n <= mac_n + 5'd1;
            // Outputs register on the first EMIT cycle, once the last product has landed.
            if (state == EMIT && !out_valid) begin
                out_valid <= 1'b1;
                out_data  <= mac_result;
                out_idx   <= k;
                out_last  <= (k == 5'd31);
            end else if (out_hs) begin
                out_valid <= 1'b0;
                k         <= (k == 5'd31) ? 5'd0 : k + 5'd1;
                if (k == 5'd31) cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) samples[cnt] <= $signed(in_data);
    end

    hevc_fdct32_mac #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .acc_en (state == MAC),
        .coef   (coef),
        .sample (samples[mac_n]),
        .result (mac_result)
    );

endmodule

// File: tb/tb_hevc_fdct32_1d.sv
// tb/tb_hevc_fdct32_1d.sv - directed self-checking bench for hevc_fdct32_1d
module tb_hevc_fdct32_1d;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;

    hevc_fdct32_1d #(.IN_W(16), .OUT_W(16), .SHIFT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int ref_edge = 0;
    int stall_changes = 0;
    int window = 0;
    int viol = 0;

    logic signed [15:0] y   [32];
    logic [4:0]         yi  [32];
    logic               yl  [32];
    int                 lat [32];

    always @(posedge clk) if (window != 0 && in_ready) viol <= viol + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send_block(input int gap_max, input logic signed [15:0] x0,
                              input logic signed [15:0] xr);
        for (int i = 0; i < 32; i++) begin
            int g;
            int guard;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i == 0) ? x0 : xr;
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("load_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ref_edge = cyc;
    endtask

    task automatic recv_one(input int stall, output logic signed [15:0] d,
                            output logic [4:0] idx, output logic l, output int lt);
        int guard;
        guard = 0;
        while (!out_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check("emit_timeout", out_valid, 1);
        lt  = cyc - ref_edge;
        d   = $signed(out_data);
        idx = out_idx;
        l   = out_last;
        repeat (stall) begin
            @(negedge clk);
            if (out_data !== d || out_idx !== idx || out_last !== l || !out_valid)
                stall_changes++;
        end
        if (idx == 5'd31) begin
            in_valid = 1'b0;
            check("ready_low_before_last_hs", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ref_edge  = cyc;
        if (idx == 5'd31) begin
            window = 0;
            check("ready_after_last_hs", in_ready, 1);
        end
    endtask

    task automatic run_block(input int gap_max, input logic signed [15:0] x0,
                             input logic signed [15:0] xr, input int stall_k,
                             input int n_out, input bit junk);
        send_block(gap_max, x0, xr);
        window = 1;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 16'h5a5a;
        end
        for (int k = 0; k < n_out; k++)
            recv_one((k == stall_k) ? 100 : 0, y[k], yi[k], yl[k], lat[k]);
    endtask

    initial begin
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);

        // flat block of 100s
        run_block(0, 16'sd100, 16'sd100, -1, 32, 1'b0);
        check("flat_y0", y[0], 12800);
        for (int k = 1; k < 32; k++) check($sformatf("flat_y%0d", k), y[k], 0);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("flat_idx%0d", k), yi[k], k);
            check($sformatf("flat_last%0d", k), yl[k], (k == 31) ? 1 : 0);
        end
        check("lat_first", lat[0], 33);
        check("lat_second", lat[1], 33);

        // impulse with junk on the input and a long stall at k=5
        stall_changes = 0;
        run_block(0, 16'sd16, 16'sd0, 5, 32, 1'b1);
        check("imp_y0", y[0], 64);
        check("imp_y1", y[1], 90);
        check("imp_y2", y[2], 90);
        check("imp_y5", y[5], 88);
        check("imp_y8", y[8], 83);
        check("imp_y16", y[16], 64);
        check("imp_y31", y[31], 4);
        check("stall_frozen", stall_changes, 0);
        check("stall_idx", yi[5], 5);
        check("lat_after_stall", lat[6], 33);

        // positive full scale saturates
        run_block(0, 16'sd32767, 16'sd32767, -1, 32, 1'b0);
        check("sat_y0", y[0], 32767);
        check("sat_y1", y[1], 0);
        check("sat_y31", y[31], 0);

        // negative impulse exercises floor rounding
        run_block(0, -16'sd8, 16'sd0, -1, 32, 1'b0);
        check("neg_y0", y[0], -32);
        check("neg_y1", y[1], -45);
        check("neg_y16", y[16], -32);

        // gapped input must match the gapless flat block
        run_block(5, 16'sd100, 16'sd100, -1, 32, 1'b0);
        check("gap_y0", y[0], 12800);
        for (int k = 1; k < 32; k++) check($sformatf("gap_y%0d", k), y[k], 0);
        check("gap_lat", lat[0], 33);
        check("ready_low_while_busy", viol, 0);

        // reset during the k=10 row
        run_block(0, 16'sd16, 16'sd0, -1, 10, 1'b0);
        window = 0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_idx", out_idx, 0);
        check("mid_rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_rst", in_ready, 1);
        run_block(0, 16'sd16, 16'sd0, -1, 32, 1'b0);
        check("post_rst_y0", y[0], 64);
        check("post_rst_y1", y[1], 90);
        check("post_rst_y31", y[31], 4);
        check("post_rst_lat", lat[0], 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
